// File: rtl/ibex_compressed_encoder.sv
// ibex_compressed_encoder
// Streaming RV32IC compressor: each accepted RV32 instruction is replaced by its
// RVC form where one exists. The resulting 16/32-bit parcels are packed into
// little-endian 32-bit words, with the first parcel in [15:0]. A packet ending on a
// half word is padded with c.nop (16'h0001).

module ibex_compressed_encoder #(
   parameter bit          EnableCompress = 1'b1,
   parameter int unsigned CntWidth       = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [31:0]         in_instr_i,
   input  logic                in_last_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [31:0]         out_data_o,
   output logic                out_last_o,
   output logic                err_o,
   output logic [CntWidth-1:0] cnt_in_o,
   output logic [CntWidth-1:0] cnt_comp_o
);

   // Major opcodes
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam logic [15:0] C_NOP     = 16'h0001;

   typedef enum logic [1:0] {
      ST_EMPTY,   // no residue held
      ST_HALF,    // a 16-bit residue waits for its partner parcel
      ST_PAD      // residue must go out alone with a c.nop pad
   } state_e;

   // Architectural state
   state_e                state_q, state_d;
   logic [15:0]           res_q, res_d;
   logic                  out_valid_q, out_valid_d;
   logic [31:0]           out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  err_q, err_d;
   logic [CntWidth-1:0]   cnt_in_q, cnt_in_d;
   logic [CntWidth-1:0]   cnt_comp_q, cnt_comp_d;

   // Instruction fields
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] imm_i, imm_s;

   assign opcode = in_instr_i[6:0];
   assign rd     = in_instr_i[11:7];
   assign funct3 = in_instr_i[14:12];
   assign rs1    = in_instr_i[19:15];
   assign rs2    = in_instr_i[24:20];
   assign funct7 = in_instr_i[31:25];
   assign imm_i  = in_instr_i[31:20];
   assign imm_s  = {in_instr_i[31:25], in_instr_i[11:7]};

   // Register usable in the 3-bit CIW/CL/CS/CA/CB register fields (x8..x15)
   function automatic logic is_prime(input logic [4:0] r);
      return r[4:3] == 2'b01;
   endfunction

   // Signed 12-bit value lies in [-32, 31]
   function automatic logic fits6(input logic [11:0] v);
      return v[11:5] == {7{v[5]}};
   endfunction

   logic        raw_hit;
   logic [15:0] c_instr;
   logic        comp_hit;

   // Compression rules; the first matching form wins, otherwise the instruction stays 32-bit
   always_comb begin
      raw_hit = 1'b0;
      c_instr = 16'h0000;
      case (opcode)
         OPC_OPIMM: begin
            case (funct3)
               3'b000: begin
                  if (rs1 == 5'd0 && rd != 5'd0 && fits6(imm_i)) begin
                     raw_hit = 1'b1;   // c.li
                     c_instr = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                  end else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && fits6(imm_i)) begin
                     raw_hit = 1'b1;   // c.addi
                     c_instr = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                  end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 &&
                               imm_i[3:0] == 4'd0 && imm_i[11:9] == {3{imm_i[9]}}) begin
                     raw_hit = 1'b1;   // c.addi16sp
                     c_instr = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6],
                                imm_i[8:7], imm_i[5], 2'b01};
                  end else if (rs1 == 5'd2 && is_prime(rd) && imm_i != 12'd0 &&
                               imm_i[1:0] == 2'd0 && imm_i[11:10] == 2'd0) begin
                     raw_hit = 1'b1;   // c.addi4spn
                     c_instr = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3],
                                rd[2:0], 2'b00};
                  end
               end
               3'b001: begin
                  if (funct7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                     raw_hit = 1'b1;   // c.slli
                     c_instr = {3'b000, 1'b0, rd, rs2, 2'b10};
                  end
               end
               3'b101: begin
                  if (rd == rs1 && is_prime(rd) && rs2 != 5'd0) begin
                     if (funct7 == 7'b0000000) begin
                        raw_hit = 1'b1;   // c.srli
                        c_instr = {3'b100, 1'b0, 2'b00, rd[2:0], rs2, 2'b01};
                     end else if (funct7 == 7'b0100000) begin
                        raw_hit = 1'b1;   // c.srai
                        c_instr = {3'b100, 1'b0, 2'b01, rd[2:0], rs2, 2'b01};
                     end
                  end
               end
               3'b111: begin
                  if (rd == rs1 && is_prime(rd) && fits6(imm_i)) begin
                     raw_hit = 1'b1;   // c.andi
                     c_instr = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
                  end
               end
               default: ;
            endcase
         end
         OPC_LUI: begin
            if (rd != 5'd0 && rd != 5'd2 && in_instr_i[31:17] == {15{in_instr_i[17]}} &&
                in_instr_i[17:12] != 6'd0) begin
               raw_hit = 1'b1;   // c.lui
               c_instr = {3'b011, in_instr_i[17], rd, in_instr_i[16:12], 2'b01};
            end
         end
         OPC_OP: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
               if (rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                  raw_hit = 1'b1;   // c.mv
                  c_instr = {4'b1000, rd, rs2, 2'b10};
               end else if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                  raw_hit = 1'b1;   // c.add
                  c_instr = {4'b1001, rd, rs2, 2'b10};
               end
            end else if (rd == rs1 && is_prime(rd) && is_prime(rs2)) begin
               if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                  raw_hit = 1'b1;   // c.sub
                  c_instr = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
               end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
                  raw_hit = 1'b1;   // c.xor
                  c_instr = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
               end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                  raw_hit = 1'b1;   // c.or
                  c_instr = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
               end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                  raw_hit = 1'b1;   // c.and
                  c_instr = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
               end
            end
         end
         OPC_LOAD: begin
            if (funct3 == 3'b010) begin
               if (is_prime(rs1) && is_prime(rd) && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
                  raw_hit = 1'b1;   // c.lw
                  c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
               end else if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0 &&
                            imm_i[1:0] == 2'd0) begin
                  raw_hit = 1'b1;   // c.lwsp
                  c_instr = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
               end
            end
         end
         OPC_STORE: begin
            if (funct3 == 3'b010) begin
               if (is_prime(rs1) && is_prime(rs2) && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
                  raw_hit = 1'b1;   // c.sw
                  c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
               end else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0) begin
                  raw_hit = 1'b1;   // c.swsp
                  c_instr = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
               end
            end
         end
         OPC_JALR: begin
            if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0) begin
               if (rd == 5'd0) begin
                  raw_hit = 1'b1;   // c.jr
                  c_instr = {4'b1000, rs1, 5'd0, 2'b10};
               end else if (rd == 5'd1) begin
                  raw_hit = 1'b1;   // c.jalr
                  c_instr = {4'b1001, rs1, 5'd0, 2'b10};
               end
            end
         end
         default: begin
            if (in_instr_i == EBREAK) begin
               raw_hit = 1'b1;   // c.ebreak
               c_instr = 16'h9002;
            end
         end
      endcase
   end

   // Handshake: the output slot is free when empty or being drained this cycle
   logic free;
   logic accept;
   logic legal;
   logic acc_legal;

   assign comp_hit   = EnableCompress && raw_hit;
   assign free       = !out_valid_q || out_ready_i;
   assign in_ready_o = free && (state_q != ST_PAD);
   assign accept     = in_valid_i && in_ready_o;
   assign legal      = (in_instr_i[1:0] == 2'b11);
   assign acc_legal  = accept && legal;

   // Packer FSM next state and output-word loading
   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      out_valid_d = out_valid_q && !out_ready_i;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (state_q == ST_PAD) begin
         if (free) begin
            out_valid_d = 1'b1;
            out_data_d  = {C_NOP, res_q};
            out_last_d  = 1'b1;
            state_d     = ST_EMPTY;
         end
      end else if (acc_legal) begin
         case (state_q)
            ST_EMPTY: begin
               if (comp_hit) begin
                  if (in_last_i) begin
                     out_valid_d = 1'b1;
                     out_data_d  = {C_NOP, c_instr};
                     out_last_d  = 1'b1;
                  end else begin
                     res_d   = c_instr;
                     state_d = ST_HALF;
                  end
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_instr_i;
                  out_last_d  = in_last_i;
               end
            end
            ST_HALF: begin
               out_valid_d = 1'b1;
               if (comp_hit) begin
                  out_data_d = {c_instr, res_q};
                  out_last_d = in_last_i;
                  state_d    = ST_EMPTY;
               end else begin
                  // Low half goes out now; the high half becomes the new residue
                  out_data_d = {in_instr_i[15:0], res_q};
                  out_last_d = 1'b0;
                  res_d      = in_instr_i[31:16];
                  state_d    = in_last_i ? ST_PAD : ST_HALF;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky error flag and saturating statistics counters
   always_comb begin
      err_d      = err_q || (accept && !legal);
      cnt_in_d   = cnt_in_q;
      cnt_comp_d = cnt_comp_q;
      if (acc_legal && !(&cnt_in_q)) begin
         cnt_in_d = cnt_in_q + CntWidth'(1);
      end
      if (acc_legal && comp_hit && !(&cnt_comp_q)) begin
         cnt_comp_d = cnt_comp_q + CntWidth'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_EMPTY;
         res_q       <= 16'h0000;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0000_0000;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
         cnt_in_q    <= '0;
         cnt_comp_q  <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
         cnt_in_q    <= cnt_in_d;
         cnt_comp_q  <= cnt_comp_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign err_o       = err_q;
   assign cnt_in_o    = cnt_in_q;
   assign cnt_comp_o  = cnt_comp_q;

endmodule

// File: tb/tb_ibex_compressed_encoder.sv
// Directed testbench for ibex_compressed_encoder. A compressing instance and a
// pass-through instance share the input stream; emitted words are collected by
// a monitor and compared against hand-computed values.

module tb_ibex_compressed_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = 32'h0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_last, err;
   logic [31:0] out_data;
   logic [15:0] cnt_in, cnt_comp;

   logic        nc_in_ready, nc_out_valid, nc_out_last, nc_err;
   logic [31:0] nc_out_data;
   logic [15:0] nc_cnt_in, nc_cnt_comp;

   int total = 0;
   int bad   = 0;

   logic [32:0] mon_q[$];
   logic [32:0] nc_q[$];

   always #5 clk = ~clk;

   ibex_compressed_encoder #(.EnableCompress(1'b1), .CntWidth(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_last_i(in_last),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
      .err_o(err), .cnt_in_o(cnt_in), .cnt_comp_o(cnt_comp)
   );

   ibex_compressed_encoder #(.EnableCompress(1'b0), .CntWidth(16)) dut_nc (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(nc_in_ready), .in_instr_i(in_instr), .in_last_i(in_last),
      .out_valid_o(nc_out_valid), .out_ready_i(out_ready), .out_data_o(nc_out_data),
      .out_last_o(nc_out_last), .err_o(nc_err), .cnt_in_o(nc_cnt_in), .cnt_comp_o(nc_cnt_comp)
   );

   // Inputs change 1 time unit after posedge, so the handshake is settled at negedge
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mon_q.push_back({out_last, out_data});
         $display("word data=%08h last=%0b", out_data, out_last);
      end
      if (rst_n && nc_out_valid && out_ready) begin
         nc_q.push_back({nc_out_last, nc_out_data});
         $display("nc word data=%08h last=%0b", nc_out_data, nc_out_last);
      end
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_q.delete();
      nc_q.delete();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and hold it until accepted (bounded)
   task automatic send(input logic [31:0] ins, input logic last);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++; bad++;
         $display("FAIL send_timeout instr=%08h ready=%0b want=1", ins, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%08h want=0", out_data); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%0b want=0", out_last); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err); end
      total++; if (cnt_in !== 16'd0 || cnt_comp !== 16'd0) begin
         bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", cnt_in, cnt_comp); end
      do_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
   endtask

   task automatic test_pair();
      do_reset();
      send(32'h0014_0413, 1'b0);
      send(32'h00B5_0533, 1'b0);
      settle();
      total++;
      if (mon_q.size() !== 1) begin
         bad++; $display("FAIL pair_count got=%0d want=1", mon_q.size());
      end else if (mon_q[0] !== {1'b0, 32'h952E_0405}) begin
         bad++; $display("FAIL pair_word got=%09h want=0952e0405", mon_q[0]);
      end
      total++; if (cnt_in !== 16'd2) begin bad++; $display("FAIL pair_cnt_in got=%0d want=2", cnt_in); end
      total++; if (cnt_comp !== 16'd2) begin bad++; $display("FAIL pair_cnt_comp got=%0d want=2", cnt_comp); end
   endtask

   task automatic test_pad();
      do_reset();
      send(32'h0014_0413, 1'b0);
      send(32'h0080_00EF, 1'b1);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pad_stall got=%0b want=0", in_ready); end
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pad_release got=%0b want=1", in_ready); end
      settle();
      total++;
      if (mon_q.size() !== 2) begin
         bad++; $display("FAIL pad_count got=%0d want=2", mon_q.size());
      end else if (mon_q[0] !== {1'b0, 32'h00EF_0405} || mon_q[1] !== {1'b1, 32'h0001_0080}) begin
         bad++; $display("FAIL pad_words got=%09h,%09h want=000ef0405,100010080", mon_q[0], mon_q[1]);
      end
      total++; if (cnt_comp !== 16'd1) begin bad++; $display("FAIL pad_cnt_comp got=%0d want=1", cnt_comp); end
   endtask

   task automatic test_single_last();
      do_reset();
      send(32'h0045_2483, 1'b1);
      settle();
      total++;
      if (mon_q.size() !== 1 || mon_q[0] !== {1'b1, 32'h0001_4144}) begin
         bad++; $display("FAIL lw_last got_n=%0d got=%09h want=100014144", mon_q.size(),
                         (mon_q.size() > 0) ? mon_q[0] : 33'h0);
      end
   endtask

   // Each vector is sent alone with last=1: compressed forms come out c.nop padded
   task automatic test_encodings();
      logic [31:0] vin[10];
      logic [31:0] vexp[10];
      vin[0] = 32'hFFF0_0293; vexp[0] = 32'h0001_52FD;   // c.li x5,-1
      vin[1] = 32'h0000_1537; vexp[1] = 32'h0001_6505;   // c.lui x10,1
      vin[2] = 32'h0010_0073; vexp[2] = 32'h0001_9002;   // c.ebreak
      vin[3] = 32'h0000_8067; vexp[3] = 32'h0001_8082;   // c.jr x1
      vin[4] = 32'h0081_2423; vexp[4] = 32'h0001_C422;   // c.swsp x8,8
      vin[5] = 32'h0400_8093; vexp[5] = 32'h0400_8093;   // addi x1,x1,64 stays 32-bit
      vin[6] = 32'hFF01_0113; vexp[6] = 32'h0001_1141;   // c.addi x2,-16
      vin[7] = 32'hFC01_0113; vexp[7] = 32'h0001_7139;   // c.addi16sp -64
      vin[8] = 32'h0101_0413; vexp[8] = 32'h0001_0800;   // c.addi4spn x8,16
      vin[9] = 32'h4034_D493; vexp[9] = 32'h0001_848D;   // c.srai x9,3
      for (int k = 0; k < 10; k++) begin
         do_reset();
         send(vin[k], 1'b1);
         settle();
         total++;
         if (mon_q.size() !== 1 || mon_q[0] !== {1'b1, vexp[k]}) begin
            bad++;
            $display("FAIL enc_%0d in=%08h got_n=%0d got=%09h want=1%08h", k, vin[k], mon_q.size(),
                     (mon_q.size() > 0) ? mon_q[0] : 33'h0, vexp[k]);
         end
      end
   endtask

   task automatic test_passthrough();
      do_reset();
      send(32'h0014_0413, 1'b0);
      send(32'h00B5_0533, 1'b0);
      settle();
      total++;
      if (nc_q.size() !== 2) begin
         bad++; $display("FAIL nc_count got=%0d want=2", nc_q.size());
      end else if (nc_q[0] !== {1'b0, 32'h0014_0413} || nc_q[1] !== {1'b0, 32'h00B5_0533}) begin
         bad++; $display("FAIL nc_words got=%09h,%09h want=000140413,000b50533", nc_q[0], nc_q[1]);
      end
      total++; if (nc_cnt_comp !== 16'd0) begin bad++; $display("FAIL nc_cnt_comp got=%0d want=0", nc_cnt_comp); end
      total++; if (nc_cnt_in !== 16'd2) begin bad++; $display("FAIL nc_cnt_in got=%0d want=2", nc_cnt_in); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      send(32'h0014_0413, 1'b0);
      send(32'h00B5_0533, 1'b0);
      in_valid = 1'b1;
      in_instr = 32'h0045_2483;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid_%0d got=%0b want=1", k, out_valid); end
         total++; if (out_data !== 32'h952E_0405) begin bad++; $display("FAIL hold_data_%0d got=%08h want=952e0405", k, out_data); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%0b want=0", k, in_ready); end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      settle();
      total++;
      if (mon_q.size() !== 2) begin
         bad++; $display("FAIL hold_count got=%0d want=2", mon_q.size());
      end else if (mon_q[0] !== {1'b0, 32'h952E_0405} || mon_q[1] !== {1'b1, 32'h0001_4144}) begin
         bad++; $display("FAIL hold_words got=%09h,%09h want=0952e0405,100014144", mon_q[0], mon_q[1]);
      end
      total++; if (cnt_in !== 16'd3) begin bad++; $display("FAIL hold_cnt_in got=%0d want=3", cnt_in); end
   endtask

   task automatic test_illegal();
      do_reset();
      send(32'h0000_0001, 1'b0);
      settle();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%0b want=1", err); end
      total++; if (cnt_in !== 16'd0) begin bad++; $display("FAIL ill_cnt_in got=%0d want=0", cnt_in); end
      total++; if (mon_q.size() !== 0) begin bad++; $display("FAIL ill_dropped got=%0d want=0", mon_q.size()); end
      send(32'h0014_0413, 1'b1);
      settle();
      total++;
      if (mon_q.size() !== 1 || mon_q[0] !== {1'b1, 32'h0001_0405}) begin
         bad++; $display("FAIL ill_next got_n=%0d want_word=100010405", mon_q.size());
      end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%0b want=1", err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      send(32'h0000_0001, 1'b0);
      send(32'h0014_0413, 1'b0);
      send(32'h0080_00EF, 1'b0);   // word pending, residue 0x0080 held
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pending got=%0b want=1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
         bad++; $display("FAIL ar_outputs got=%0b/%08h/%0b want=0/00000000/0", out_valid, out_data, out_last); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ar_err got=%0b want=0", err); end
      total++; if (cnt_in !== 16'd0 || cnt_comp !== 16'd0) begin
         bad++; $display("FAIL ar_counters got=%0d/%0d want=0/0", cnt_in, cnt_comp); end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      mon_q.delete();
      nc_q.delete();
      send(32'h0045_2483, 1'b1);
      settle();
      total++;
      if (mon_q.size() !== 1 || mon_q[0] !== {1'b1, 32'h0001_4144}) begin
         bad++; $display("FAIL ar_residue got_n=%0d got=%09h want=100014144", mon_q.size(),
                         (mon_q.size() > 0) ? mon_q[0] : 33'h0);
      end
   endtask

   initial begin
      test_reset();
      test_pair();
      test_pad();
      test_single_last();
      test_encodings();
      test_passthrough();
      test_back_to_back();
      test_illegal();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
